// File: rtl/timer_sched.sv
// Round-robin shared countdown timer: one requester owns the timer, counts its load value to zero, gets a done pulse.
// Optional abort input and its cancel path are built only when TIMER_SCHED_ABORT_EN is defined.
module timer_sched #(
    parameter int NREQ = 4,
    parameter int W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_val,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      count
`ifdef TIMER_SCHED_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [NREQ-1:0] grant_r, grant_s;
    logic [NREQ-1:0] done_r,  done_s;
    logic            busy_r,  busy_s;
    logic [W-1:0]    count_r, count_s;
    logic [PW-1:0]   ptr_r,   ptr_s;
    logic [PW-1:0]   owner_r, owner_s;
    logic [PW-1:0]   win_s;
    logic [W-1:0]    load_s;

    // First requester at or above p, wrapping at NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        logic          found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(p) + k) % NREQ);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [W-1:0] sel_val(input logic [NREQ*W-1:0] v, input logic [PW-1:0] i);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (i == PW'(k)) begin
                r = v[k*W +: W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] oh;
        for (int k = 0; k < NREQ; k++) begin
            oh[k] = (i == PW'(k));
        end
        return oh;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? {PW{1'b0}} : (i + PW'(1'b1));
    endfunction

    // Arbitration candidate and its load value, evaluated every cycle but used only in IDLE.
    always_comb begin
        win_s  = rr_pick(req, ptr_r);
        load_s = sel_val(req_val, win_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        done_s  = {NREQ{1'b0}};
        count_s = count_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s = ST_RUN;
                    grant_s = onehot(win_s);
                    count_s = load_s;
                    owner_s = win_s;
                end else begin
                    grant_s = {NREQ{1'b0}};
                end
            end
            ST_RUN: begin
`ifdef TIMER_SCHED_ABORT_EN
                // Abort beats expiry even when count has already reached zero.
                if (abort) begin
                    state_s = ST_IDLE;
                    grant_s = {NREQ{1'b0}};
                    ptr_s   = next_ptr(owner_r);
                end else
`endif
                if (count_r != {W{1'b0}}) begin
                    count_s = count_r - W'(1'b1);
                end else begin
                    state_s = ST_DONE;
                    grant_s = {NREQ{1'b0}};
                    done_s  = onehot(owner_r);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                grant_s = {NREQ{1'b0}};
                ptr_s   = next_ptr(owner_r);
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {NREQ{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= {NREQ{1'b0}};
            done_r  <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            count_r <= {W{1'b0}};
            ptr_r   <= {PW{1'b0}};
            owner_r <= {PW{1'b0}};
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            count_r <= count_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
        end
    end

    assign grant = grant_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign count = count_r;

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the timer.
REQ-002 The block SHALL have parameter W, default 10, meaning the count width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-005 The block SHALL have port req  input  NREQ  per-requester timer request, level.
REQ-006 The block SHALL have port req_val  input  NREQ*W  load value; requester i uses bits [i*W +: W].
REQ-007 The block SHALL have port grant  output  NREQ  one-hot owner of the timer; all-zero when no owner.
REQ-008 The block SHALL have port done  output  NREQ  one-cycle expiry pulse to the owner.
REQ-009 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have port count  output  W  current timer value.
REQ-011 The block SHALL have port abort  input  1  cancel the running timer; the port exists only when TIMER_SCHED_ABORT_EN is defined.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 In IDLE with req nonzero, at the next edge the block SHALL:
- select winner w by round-robin, searching upward from ptr and wrapping at NREQ;
- set grant to onehot(w);
- load count with req_val[w];
- enter RUN.
REQ-014 In IDLE with req all-zero, the block SHALL hold grant=0 and hold count.
REQ-015 In RUN, each edge SHALL decrement count by 1 if count is nonzero; if count is zero, the block SHALL enter DONE instead.
REQ-016 In DONE, the block SHALL assert done[w] for exactly one cycle, drive grant=0, set ptr=(w+1) mod NREQ, and return to IDLE at the next edge.
REQ-017 done[w] SHALL first assert exactly V+1 cycles after grant[w] first asserts, where V is the loaded value; grant SHALL deassert in the same cycle.
REQ-018 A load value of 0 SHALL give one RUN cycle and then DONE; no wrap-around to 2^W-1 is permitted.
REQ-019 A load value of 2^W-1 SHALL count fully down without overflow; arithmetic SHALL be unsigned W-bit.
REQ-020 req and req_val changes while in RUN or DONE SHALL be ignored; the loaded value is captured only at grant.
REQ-021 The owner dropping req during RUN SHALL NOT stop the timer.
REQ-022 There SHALL be at least one IDLE cycle between consecutive grants.
REQ-023 done SHALL be at most one-hot, grant SHALL be at most one-hot, and grant and done SHALL never be simultaneously nonzero.

Reset
REQ-024 When rst_n is low at an edge, the block SHALL set state=IDLE, grant=0, done=0, busy=0, count=0 and ptr=0.
REQ-025 Reset asserted mid-RUN or mid-DONE SHALL abandon the timer with no done pulse.

Configuration
REQ-026 With TIMER_SCHED_ABORT_EN defined, abort high in RUN SHALL cause the next edge to:
- enter IDLE;
- set grant=0;
- suppress done;
- set ptr=(w+1) mod NREQ;
- hold count.
REQ-027 With TIMER_SCHED_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE.
REQ-028 With TIMER_SCHED_ABORT_EN defined, if abort is high in the same cycle count reaches zero in RUN, the abort SHALL win and no done pulse SHALL be issued.
REQ-029 Without TIMER_SCHED_ABORT_EN, the abort port and its logic SHALL be absent, and the block SHALL behave as REQ-012 to REQ-023.

Verification
REQ-030 The bench SHALL cover: reset, then req=4'b0001 with val0=3 -> grant=0001 for 4 cycles, count 3,2,1,0, then done=0001 for 1 cycle, busy low the cycle after.
REQ-031 The bench SHALL cover: req=4'b1111 held with all vals 0 -> grants rotate 0001,0010,0100,1000,0001, each followed by a done pulse 1 cycle after grant.
REQ-032 The bench SHALL cover: val=10'h3FF -> done 1024 cycles after grant, count never exceeds 0x3FF.
REQ-033 The bench SHALL cover: rst_n low mid-RUN with count=5 -> next cycle grant=0, count=0, busy=0, no done pulse.
REQ-034 The bench SHALL cover: owner drops req and req_val changes during RUN -> expiry time unchanged.
REQ-035 With TIMER_SCHED_ABORT_EN defined, the bench SHALL cover: abort in RUN at count=2 with req=0011 and owner 0 -> no done, one IDLE cycle, then grant=0010.
